// File: rtl/holder_conditioner.sv
// Slide-switch conditioner: synchronizes and debounces a 2-bit holder and emits change/tick/advance strobes.
// Optional periodic tick generator is compiled in when HOLDER_TICK_EN is defined.
module holder_conditioner #(
    parameter int          DEBOUNCE_CYCLES = 4,
    parameter logic [31:0] TICK_CYCLES     = 32'd100_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] raw_holder,
    output logic [1:0] holder,
    output logic       changed,
    output logic       tick,
    output logic       advance
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync1_q;
    logic [1:0]    sync_q;
    logic [1:0]    cand_q;
    logic [1:0]    cand_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [1:0]    holder_q;
    logic [1:0]    holder_d;
    logic          changed_q;
    logic          advance_q;
    logic          load_s;
    logic          tick_s;

    // Two-flop synchronizer; only the second stage feeds the debouncer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 2'b00;
            sync_q  <= 2'b00;
        end else begin
            sync1_q <= raw_holder;
            sync_q  <= sync1_q;
        end
    end

    // Debounce next-state: the word must hold DEBOUNCE_CYCLES matching cycles after a restart.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        holder_d = holder_q;
        load_s   = 1'b0;
        if (sync_q == holder_q) begin
            cand_d = sync_q;
            cnt_d  = {CW{1'b0}};
        end else if (sync_q != cand_q) begin
            cand_d = sync_q;
            cnt_d  = {CW{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
            holder_d = cand_q;
            cnt_d    = {CW{1'b0}};
            load_s   = 1'b1;
        end else begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q   <= 2'b00;
            cnt_q    <= {CW{1'b0}};
            holder_q <= 2'b00;
        end else begin
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            holder_q <= holder_d;
        end
    end

`ifdef HOLDER_TICK_EN
    logic [31:0] tick_cnt_q;
    logic [31:0] tick_cnt_d;
    logic        tick_q;

    // Tick counter restarts on wrap and on every holder update, so a coincident pair restarts once.
    always_comb begin
        tick_s = (tick_cnt_q == (TICK_CYCLES - 32'd1));
        if (load_s || tick_s) begin
            tick_cnt_d = 32'd0;
        end else begin
            tick_cnt_d = tick_cnt_q + 32'd1;
        end
    end

    // Tick counter and registered tick strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= 32'd0;
            tick_q     <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            tick_q     <= tick_s;
        end
    end

    assign tick = tick_q;
`else
    logic unused_tick_cfg_s;

    assign unused_tick_cfg_s = ^TICK_CYCLES;
    assign tick_s            = 1'b0;
    assign tick              = 1'b0;
`endif

    // Registered strobes; advance merges change and tick into one pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            changed_q <= 1'b0;
            advance_q <= 1'b0;
        end else begin
            changed_q <= load_s;
            advance_q <= load_s | tick_s;
        end
    end

    assign holder  = holder_q;
    assign changed = changed_q;
    assign advance = advance_q;

endmodule

// File: tb/tb_holder_conditioner.sv
// Directed bench for holder_conditioner with DEBOUNCE_CYCLES=4, TICK_CYCLES=10.
// Tick expectations follow HOLDER_TICK_EN as seen by this compile.
module tb_holder_conditioner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] raw_holder = 2'b00;
    logic [1:0] holder;
    logic       changed;
    logic       tick;
    logic       advance;

    int n_run  = 0;
    int n_fail = 0;

`ifdef HOLDER_TICK_EN
    localparam bit TICK_ON = 1'b1;
`else
    localparam bit TICK_ON = 1'b0;
`endif

    holder_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .TICK_CYCLES    (32'd10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw_holder(raw_holder),
        .holder    (holder),
        .changed   (changed),
        .tick      (tick),
        .advance   (advance)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cyc(input string sc, input int n, input logic [1:0] h,
                           input logic ch, input logic tk);
        logic tk_e;
        tk_e = tk & TICK_ON;
        chk($sformatf("%s.holder@%0d", sc, n),  holder,          h);
        chk($sformatf("%s.changed@%0d", sc, n), {1'b0, changed}, {1'b0, ch});
        chk($sformatf("%s.tick@%0d", sc, n),    {1'b0, tick},    {1'b0, tk_e});
        chk($sformatf("%s.advance@%0d", sc, n), {1'b0, advance}, {1'b0, ch | tk_e});
    endtask

    task automatic chk_zero(input string sc);
        chk({sc, ".rst_holder"},  holder,          2'b00);
        chk({sc, ".rst_changed"}, {1'b0, changed}, 2'b00);
        chk({sc, ".rst_tick"},    {1'b0, tick},    2'b00);
        chk({sc, ".rst_advance"}, {1'b0, advance}, 2'b00);
    endtask

    task automatic do_reset(input string sc, input logic [1:0] r);
        raw_holder = r;
        rst_n      = 1'b0;
        #1;
        chk_zero(sc);
        step();
        step();
        step();
        chk_zero(sc);
        rst_n = 1'b1;
    endtask

    initial begin
        // Raw held at 11 through reset: accepted at edge 7 after release, tick restarts there.
        do_reset("pwr", 2'b11);
        for (int n = 1; n <= 18; n++) begin
            step();
            chk_cyc("pwr", n, (n >= 7) ? 2'b11 : 2'b00, n == 7, n == 17);
        end

        // Stable input: ticks every 10 cycles, no change.
        do_reset("per", 2'b00);
        for (int n = 1; n <= 50; n++) begin
            step();
            chk_cyc("per", n, 2'b00, 1'b0, (n % 10) == 0);
        end

        // Short 3-cycle glitch on 01 is rejected.
        raw_holder = 2'b01;
        for (int n = 51; n <= 62; n++) begin
            step();
            if (n == 53) raw_holder = 2'b00;
            chk_cyc("glitch", n, 2'b00, 1'b0, (n % 10) == 0);
        end

        // Bouncing 01/10 every 2 cycles, then settle on 10.
        do_reset("bounce", 2'b00);
        for (int n = 1; n <= 28; n++) begin
            if (n <= 10) raw_holder = (((n - 1) / 2) % 2 == 0) ? 2'b01 : 2'b10;
            else         raw_holder = 2'b10;
            step();
            chk_cyc("bounce", n, (n >= 17) ? 2'b10 : 2'b00, n == 17, (n == 10) || (n == 27));
        end

        // Change lands on the tick cycle: one advance pulse, tick period restarts.
        do_reset("coinc", 2'b00);
        for (int n = 1; n <= 21; n++) begin
            step();
            if (n == 3) raw_holder = 2'b01;
            chk_cyc("coinc", n, (n >= 10) ? 2'b01 : 2'b00, n == 10, (n == 10) || (n == 20));
        end

        // Reset mid-debounce abandons the pending 01.
        do_reset("midrst", 2'b00);
        raw_holder = 2'b01;
        for (int n = 1; n <= 4; n++) begin
            step();
            chk_cyc("midrst", n, 2'b00, 1'b0, 1'b0);
        end
        rst_n = 1'b0;
        #1;
        chk_zero("midrst_a");
        step();
        chk_zero("midrst_b");
        rst_n = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            step();
            chk_cyc("midrst_rel", n, (n >= 7) ? 2'b01 : 2'b00, n == 7, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
